// File: rtl/fifo_sync_pkg.sv
// Shared defaults and helpers for the synchronous programmable-threshold FIFO.
// Imported by fifo_sync_prog; the storage sub-module is kept parameter-only.
package fifo_sync_pkg;

  localparam int unsigned FIFO_DATASIZE_DEF = 8;
  localparam int unsigned FIFO_ADDRSIZE_DEF = 4;

  // Fill level needs one bit more than the pointers so that DEPTH itself fits.
  function automatic int unsigned cnt_width(input int unsigned addrsize);
    return addrsize + 1;
  endfunction

  // Encoded as {read_accepted, write_accepted}.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_WR    = 2'b01,
    OP_RD    = 2'b10,
    OP_WR_RD = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/fifo_sync_ram.sv
// DEPTH x DATASIZE storage: one synchronous write port, one asynchronous read port.
// The array is deliberately not reset; the control logic decides which words are live.
module fifo_sync_ram #(
  parameter int unsigned DATASIZE = 8,
  parameter int unsigned ADDRSIZE = 4
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [ADDRSIZE-1:0] waddr_i,
  input  logic [DATASIZE-1:0] wdata_i,
  input  logic [ADDRSIZE-1:0] raddr_i,
  output logic [DATASIZE-1:0] rdata_o
);

  localparam int unsigned DEPTH = 2 ** ADDRSIZE;

  logic [DATASIZE-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO with registered fill count, programmable almost-full/almost-empty
// thresholds and sticky overflow/underflow flags. Define FIFO_SYNC_FWFT_EN for FWFT reads.
module fifo_sync_prog
  import fifo_sync_pkg::*;
#(
  parameter int unsigned DATASIZE = FIFO_DATASIZE_DEF,
  parameter int unsigned ADDRSIZE = FIFO_ADDRSIZE_DEF
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [DATASIZE-1:0]                wdata_i,
  input  logic                               winc_i,
  input  logic                               rinc_i,
  input  logic                               clr_i,
  input  logic [cnt_width(ADDRSIZE)-1:0]     afull_th_i,
  input  logic [cnt_width(ADDRSIZE)-1:0]     aempty_th_i,
  output logic [DATASIZE-1:0]                rdata_o,
  output logic                               rvalid_o,
  output logic                               wfull_o,
  output logic                               rempty_o,
  output logic                               w_almost_full_o,
  output logic                               r_almost_empty_o,
  output logic [cnt_width(ADDRSIZE)-1:0]     count_o,
  output logic                               overflow_o,
  output logic                               underflow_o
);

  localparam int unsigned CW = cnt_width(ADDRSIZE);
  localparam logic [CW-1:0] DEPTH_C = CW'(2 ** ADDRSIZE);

  logic [ADDRSIZE-1:0] wptr_q, wptr_d;
  logic [ADDRSIZE-1:0] rptr_q, rptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;

  logic                wfull;
  logic                rempty;
  logic                wr_acc;
  logic                rd_acc;
  logic                ram_we;
  logic [DATASIZE-1:0] ram_rdata;
  fifo_op_e            op;

  // Flags come straight off the registered count so they carry no extra latency.
  assign wfull  = (count_q == DEPTH_C);
  assign rempty = (count_q == '0);

  assign wr_acc = winc_i & ~wfull;
  assign rd_acc = rinc_i & ~rempty;
  assign op     = fifo_op_e'({rd_acc, wr_acc});

  // A flush wins over a same-cycle write, so the array must not see that write either.
  assign ram_we = wr_acc & ~clr_i;

  fifo_sync_ram #(
    .DATASIZE (DATASIZE),
    .ADDRSIZE (ADDRSIZE)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .waddr_i (wptr_q),
    .wdata_i (wdata_i),
    .raddr_i (rptr_q),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (clr_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      if (wr_acc) begin
        wptr_d = wptr_q + 1'b1;
      end
      if (rd_acc) begin
        rptr_d = rptr_q + 1'b1;
      end
      case (op)
        OP_WR:   count_d = count_q + 1'b1;
        OP_RD:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (winc_i && wfull) begin
        ovf_d = 1'b1;
      end
      if (rinc_i && rempty) begin
        unf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

`ifdef FIFO_SYNC_FWFT_EN
  // Head word is visible whenever the FIFO holds data; forced to zero while empty.
  assign rdata_o  = rempty ? '0 : ram_rdata;
  assign rvalid_o = ~rempty;
`else
  logic [DATASIZE-1:0] rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;

  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    if (!clr_i && rd_acc) begin
      rdata_d  = ram_rdata;
      rvalid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;
`endif

  assign wfull_o          = wfull;
  assign rempty_o         = rempty;
  assign w_almost_full_o  = (count_q >= afull_th_i);
  assign r_almost_empty_o = (count_q <= aempty_th_i);
  assign count_o          = count_q;
  assign overflow_o       = ovf_q;
  assign underflow_o      = unf_q;

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Directed bench for fifo_sync_prog: a queue-based reference model checked every cycle,
// plus hand-computed literal expectations at key points of each scenario.
module tb_fifo_sync_prog;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] wdata = '0;
  logic          winc = 1'b0;
  logic          rinc = 1'b0;
  logic          clr = 1'b0;
  logic [AW:0]   afull_th = 5'd14;
  logic [AW:0]   aempty_th = 5'd2;
  logic [DW-1:0] rdata;
  logic          rvalid, wfull, rempty, afull, aempty, ovf, unf;
  logic [AW:0]   count;

  int total = 0;
  int bad = 0;

  fifo_sync_prog #(.DATASIZE(DW), .ADDRSIZE(AW)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .wdata_i          (wdata),
    .winc_i           (winc),
    .rinc_i           (rinc),
    .clr_i            (clr),
    .afull_th_i       (afull_th),
    .aempty_th_i      (aempty_th),
    .rdata_o          (rdata),
    .rvalid_o         (rvalid),
    .wfull_o          (wfull),
    .rempty_o         (rempty),
    .w_almost_full_o  (afull),
    .r_almost_empty_o (aempty),
    .count_o          (count),
    .overflow_o       (ovf),
    .underflow_o      (unf)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: contents as a queue, registered read output as plain variables.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rdata = '0;
  logic          m_rvalid = 1'b0;
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;
  bit            m_full, m_empty;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_rdata = '0;
      m_rvalid = 1'b0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (clr) begin
      q.delete();
      m_rvalid = 1'b0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      m_full = (q.size() == DEPTH);
      m_empty = (q.size() == 0);
      if (winc && m_full) m_ovf = 1'b1;
      if (rinc && m_empty) m_unf = 1'b1;
      m_rvalid = 1'b0;
      if (rinc && !m_empty) begin
        m_rdata = q.pop_front();
        m_rvalid = 1'b1;
      end
      if (winc && !m_full) q.push_back(wdata);
    end
  end

  always @(negedge clk) begin
    chk("count", 32'(count), 32'(q.size()));
    chk("wfull", 32'(wfull), 32'(q.size() == DEPTH));
    chk("rempty", 32'(rempty), 32'(q.size() == 0));
    chk("afull", 32'(afull), 32'(q.size() >= int'(afull_th)));
    chk("aempty", 32'(aempty), 32'(q.size() <= int'(aempty_th)));
    chk("overflow", 32'(ovf), 32'(m_ovf));
    chk("underflow", 32'(unf), 32'(m_unf));
`ifdef FIFO_SYNC_FWFT_EN
    chk("rvalid", 32'(rvalid), 32'(q.size() != 0));
    if (q.size() != 0) chk("rdata", 32'(rdata), 32'(q[0]));
`else
    chk("rvalid", 32'(rvalid), 32'(m_rvalid));
    chk("rdata", 32'(rdata), 32'(m_rdata));
`endif
  end

  task automatic cyc(input logic w, input logic [DW-1:0] wd, input logic r, input logic c);
    winc = w;
    wdata = wd;
    rinc = r;
    clr = c;
    @(posedge clk);
    #1;
    winc = 1'b0;
    rinc = 1'b0;
    clr = 1'b0;
  endtask

  // Read with an expected word; the check sits before or after the edge depending on latency.
  task automatic rd_exp(input logic w, input logic [DW-1:0] wd, input logic [DW-1:0] exp);
`ifdef FIFO_SYNC_FWFT_EN
    chk("fwft_head", 32'(rdata), 32'(exp));
    chk("fwft_valid", 32'(rvalid), 32'd1);
    cyc(w, wd, 1'b1, 1'b0);
`else
    cyc(w, wd, 1'b1, 1'b0);
    chk("rd_word", 32'(rdata), 32'(exp));
    chk("rd_valid", 32'(rvalid), 32'd1);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_rempty", 32'(rempty), 32'd1);
    chk("rst_wfull", 32'(wfull), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_aempty", 32'(aempty), 32'd1);
    chk("rst_afull", 32'(afull), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Fill with 0x01..0x10.
    for (int i = 1; i <= DEPTH; i++) begin
      cyc(1'b1, DW'(i), 1'b0, 1'b0);
      chk("fill_count", 32'(count), 32'(i));
      chk("fill_afull", 32'(afull), 32'(i >= 14));
    end
    chk("full_flag", 32'(wfull), 32'd1);

    // Write into full FIFO.
    cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("ovf_set", 32'(ovf), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);

    // Drain in order; 0xAA must never appear.
    for (int i = 1; i <= DEPTH; i++) rd_exp(1'b0, '0, DW'(i));
    chk("drain_empty", 32'(rempty), 32'd1);
    chk("ovf_sticky", 32'(ovf), 32'd1);

    // Read from empty FIFO, then flush the flags.
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("unf_set", 32'(unf), 32'd1);
    chk("unf_rvalid", 32'(rvalid), 32'd0);
    chk("unf_count", 32'(count), 32'd0);
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("clr_unf", 32'(unf), 32'd0);
    chk("clr_ovf", 32'(ovf), 32'd0);

    // Level-one streaming: 40 concurrent read/write cycles wrap both pointers.
    cyc(1'b1, 8'h40, 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      rd_exp(1'b1, DW'(8'h41 + k), DW'(8'h40 + k));
      chk("lvl1_count", 32'(count), 32'd1);
    end
    rd_exp(1'b0, '0, 8'h68);
    chk("lvl1_empty", 32'(rempty), 32'd1);

    // Flush at level nine overrides a same-cycle write.
    for (int i = 0; i < 9; i++) cyc(1'b1, DW'(8'h90 + i), 1'b0, 1'b0);
    chk("pre_clr_count", 32'(count), 32'd9);
    cyc(1'b1, 8'h77, 1'b0, 1'b1);
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_rempty", 32'(rempty), 32'd1);
    chk("clr_rvalid", 32'(rvalid), 32'd0);

    // Full FIFO with simultaneous read and write: write rejected, read accepted.
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, DW'(8'hC0 + i), 1'b0, 1'b0);
    rd_exp(1'b1, 8'h99, 8'hC0);
    chk("full_rw_count", 32'(count), 32'd15);
    chk("full_rw_ovf", 32'(ovf), 32'd1);
    rd_exp(1'b0, '0, 8'hC1);

    // Reset mid-burst takes effect without a clock edge.
    cyc(1'b1, 8'h11, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_rempty", 32'(rempty), 32'd1);
    chk("arst_wfull", 32'(wfull), 32'd0);
    chk("arst_rvalid", 32'(rvalid), 32'd0);
    chk("arst_rdata", 32'(rdata), 32'd0);
    chk("arst_ovf", 32'(ovf), 32'd0);
    chk("arst_aempty", 32'(aempty), 32'd1);
    do_reset();

    // Single write then observe the read path.
    cyc(1'b1, 8'h5C, 1'b0, 1'b0);
`ifdef FIFO_SYNC_FWFT_EN
    chk("fwft_5c_data", 32'(rdata), 32'h5C);
    chk("fwft_5c_valid", 32'(rvalid), 32'd1);
`else
    chk("std_5c_novalid", 32'(rvalid), 32'd0);
`endif
    rd_exp(1'b0, '0, 8'h5C);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("end_rvalid", 32'(rvalid), 32'd0);

    // Threshold boundary: afull at threshold 0 is always set.
    afull_th = 5'd0;
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("th0_afull", 32'(afull), 32'd1);
    afull_th = 5'd14;
    cyc(1'b0, '0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
